dac_cfg_sequencer: RTL and testbench

Upstream controller for the DAC SPI master. After reset it writes a parameterised table of DAC register values through the SPI master and reads each one back to verify it. It retries on mismatch or timeout, then reports init status. Once initialised, it arbitrates single-register host read/write requests onto the same SPI master interface.

---
 rtl/dac_cfg_sequencer_if.sv | 30 +++
 rtl/dac_cfg_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dac_cfg_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_cfg_sequencer_if.sv
// Bus bundle between the DAC config sequencer, the DAC SPI master
// and the host port.
interface dac_cfg_sequencer_if;
    logic [5:0] spi_reg;
    logic [7:0] spi_data_in;
    logic       spi_rw;
    logic       spi_send;
    logic       spi_done;
    logic [7:0] spi_data_out;
    logic       host_req;
    logic       host_rw;
    logic [5:0] host_reg;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;

    modport master (
        output spi_reg, spi_data_in, spi_rw, spi_send,
        output host_ack, host_rdata,
        input  spi_done, spi_data_out,
        input  host_req, host_rw, host_reg, host_wdata
    );

    modport slave (
        input  spi_reg, spi_data_in, spi_rw, spi_send,
        input  host_ack, host_rdata,
        output spi_done, spi_data_out,
        output host_req, host_rw, host_reg, host_wdata
    );
endinterface

// File: rtl/dac_cfg_sequencer.sv
// DAC register init sequencer: writes and verifies a static table,
// then forwards single host register transfers to the SPI master.
module dac_cfg_sequencer #(
    parameter int NUM_REGS       = 8,
    parameter int STARTUP_DELAY  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REGS*14-1:0] init_table,
    dac_cfg_sequencer_if.master    bus,
    output logic                   init_done,
    output logic                   init_error,
    output logic [4:0]             err_index
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   PWR_LAST = 16'(STARTUP_DELAY - 1);
    localparam logic [4:0]    IDX_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        WAIT_PWR, LOAD, SEND, WAIT_ACK,
        WAIT_DONE, CHECK, READY, ERROR
    } state_t;

    state_t        state;
    logic [15:0]   pwr_cnt;
    logic [TW-1:0] tcnt;
    logic [4:0]    idx;
    logic [RW-1:0] retry;
    logic          host_op;
    logic          fail;
    logic [7:0]    rd_q;
    logic [13:0]   entry;
    logic          tmo;

    always_comb begin
        entry = init_table[int'(idx)*14 +: 14];
        tmo   = (tcnt == T_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_PWR;
            pwr_cnt         <= '0;
            tcnt            <= '0;
            idx             <= '0;
            retry           <= '0;
            host_op         <= 1'b0;
            fail            <= 1'b0;
            rd_q            <= '0;
            bus.spi_reg     <= '0;
            bus.spi_data_in <= '0;
            bus.spi_rw      <= 1'b1;
            bus.spi_send    <= 1'b0;
            bus.host_ack    <= 1'b0;
            bus.host_rdata  <= '0;
            init_done       <= 1'b0;
            init_error      <= 1'b0;
            err_index       <= '0;
        end else begin
            bus.spi_send <= 1'b0;
            bus.host_ack <= 1'b0;
            unique case (state)
                WAIT_PWR: begin
                    if (pwr_cnt == PWR_LAST) begin
                        idx   <= '0;
                        retry <= '0;
                        state <= LOAD;
                    end else begin
                        pwr_cnt <= pwr_cnt + 16'd1;
                    end
                end
                LOAD: begin
                    bus.spi_reg     <= entry[13:8];
                    bus.spi_data_in <= entry[7:0];
                    bus.spi_rw      <= 1'b1;
                    host_op         <= 1'b0;
                    state           <= SEND;
                end
                SEND: begin
                    if (bus.spi_done) begin
                        bus.spi_send <= 1'b1;
                        tcnt         <= '0;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (!bus.spi_done) begin
                        tcnt  <= tcnt + 1'b1;
                        state <= WAIT_DONE;
                    end else if (tmo) begin
                        if (host_op) begin
                            bus.host_ack   <= 1'b1;
                            bus.host_rdata <= 8'hFF;
                            state          <= READY;
                        end else begin
                            fail  <= 1'b1;
                            state <= CHECK;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.spi_done) begin
                        if (host_op) begin
                            bus.host_ack <= 1'b1;
                            if (!bus.spi_rw)
                                bus.host_rdata <= bus.spi_data_out;
                            state <= READY;
                        end else if (bus.spi_rw) begin
                            // write phase done, read the same register back
                            bus.spi_rw <= 1'b0;
                            state      <= SEND;
                        end else begin
                            rd_q  <= bus.spi_data_out;
                            fail  <= 1'b0;
                            state <= CHECK;
                        end
                    end else if (tmo) begin
                        if (host_op) begin
                            bus.host_ack   <= 1'b1;
                            bus.host_rdata <= 8'hFF;
                            state          <= READY;
                        end else begin
                            fail  <= 1'b1;
                            state <= CHECK;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!fail && rd_q == entry[7:0]) begin
                        if (idx == IDX_LAST) begin
                            init_done <= 1'b1;
                            state     <= READY;
                        end else begin
                            idx   <= idx + 5'd1;
                            retry <= '0;
                            state <= LOAD;
                        end
                    end else if (int'(retry) < MAX_RETRIES) begin
                        retry <= retry + 1'b1;
                        state <= LOAD;
                    end else begin
                        init_error <= 1'b1;
                        err_index  <= idx;
                        state      <= ERROR;
                    end
                end
                READY: begin
                    if (bus.host_req) begin
                        host_op         <= 1'b1;
                        bus.spi_rw      <= bus.host_rw;
                        bus.spi_reg     <= bus.host_reg;
                        bus.spi_data_in <= bus.host_wdata;
                        state           <= SEND;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Bench for dac_cfg_sequencer: behavioural SPI master model plus a
// transfer scoreboard checked at every spi_send.
module tb_dac_cfg_sequencer;
    localparam int NR  = 2;
    localparam int SD  = 16;
    localparam int TO  = 64;
    localparam int MR  = 3;

    typedef struct {
        logic       rw;
        logic [5:0] r;
        logic [7:0] d;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*14-1:0] init_table = {6'h05, 8'h3C, 6'h03, 8'h5A};
    logic init_done;
    logic init_error;
    logic [4:0] err_index;

    dac_cfg_sequencer_if bus();

    dac_cfg_sequencer #(
        .NUM_REGS(NR),
        .STARTUP_DELAY(SD),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR)
    ) dut (
        .clk(clk),
        .reset_n(rst_n),
        .init_table(init_table),
        .bus(bus),
        .init_done(init_done),
        .init_error(init_error),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int n_send = 0;
    int first_send = 0;
    int cyc = 0;
    int send_cyc[$];
    xfer_t exp_q[$];
    logic [7:0] rd_exp_q[$];

    // SPI master model: mode 0 echo, 1 zero on first read of reg 5,
    // 2 corrupt reads of reg 3, 3 stuck (never accepts).
    logic [7:0] mem [64];
    logic [2:0] busy;
    logic       m_rw;
    logic [5:0] m_reg;
    logic       zero_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spi_done     <= 1'b1;
            bus.spi_data_out <= 8'h00;
            busy             <= 3'd0;
            m_rw             <= 1'b1;
            m_reg            <= 6'h00;
            zero_done        <= 1'b0;
        end else if (busy != 3'd0) begin
            busy <= busy - 3'd1;
            if (busy == 3'd1) begin
                bus.spi_done <= 1'b1;
                if (!m_rw) begin
                    if (mode == 2 && m_reg == 6'h03)
                        bus.spi_data_out <= ~mem[m_reg];
                    else if (mode == 1 && m_reg == 6'h05 && !zero_done) begin
                        bus.spi_data_out <= 8'h00;
                        zero_done        <= 1'b1;
                    end else
                        bus.spi_data_out <= mem[m_reg];
                end
            end
        end else if (bus.spi_send && mode != 3) begin
            bus.spi_done <= 1'b0;
            busy         <= 3'd3;
            m_rw         <= bus.spi_rw;
            m_reg        <= bus.spi_reg;
            if (bus.spi_rw)
                mem[bus.spi_reg] <= bus.spi_data_in;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && bus.spi_send) begin
            if (n_send == 0) first_send = cyc;
            send_cyc.push_back(cyc);
            n_send++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_xfer rw=%0b reg=%h data=%h expected none",
                         bus.spi_rw, bus.spi_reg, bus.spi_data_in);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                if (bus.spi_rw !== e.rw || bus.spi_reg !== e.r ||
                    (e.rw && bus.spi_data_in !== e.d)) begin
                    failures++;
                    $display("FAIL xfer got rw=%0b reg=%h data=%h expected rw=%0b reg=%h data=%h",
                             bus.spi_rw, bus.spi_reg, bus.spi_data_in, e.rw, e.r, e.d);
                end
            end
        end
    end

    task automatic push_x(input logic rw, input logic [5:0] r, input logic [7:0] d);
        xfer_t e;
        e.rw = rw;
        e.r  = r;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_pair(input int i);
        logic [13:0] e;
        e = init_table[i*14 +: 14];
        push_x(1'b1, e[13:8], e[7:0]);
        push_x(1'b0, e[13:8], 8'h00);
    endtask

    task automatic hold_reset(input int m);
        rst_n = 1'b0;
        bus.host_req = 1'b0;
        mode = m;
        exp_q.delete();
        send_cyc.delete();
        n_send = 0;
        first_send = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input int lim, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk);
            if (init_done || init_error) hit = 1'b1;
        end
    endtask

    task automatic host_xfer(input logic rw, input logic [5:0] r, input logic [7:0] d,
                             output bit got, output logic [7:0] rdata, output int width);
        got = 1'b0;
        width = 0;
        rdata = 8'h00;
        @(negedge clk);
        bus.host_req   = 1'b1;
        bus.host_rw    = rw;
        bus.host_reg   = r;
        bus.host_wdata = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.host_ack) begin
                got = 1'b1;
                rdata = bus.host_rdata;
            end
        end
        bus.host_req = 1'b0;
        if (got) begin
            width = 1;
            @(negedge clk);
            if (bus.host_ack) width++;
        end
    endtask

    task automatic test_reset();
        hold_reset(0);
        #1;
        checks++;
        if (bus.spi_reg !== 6'h00 || bus.spi_data_in !== 8'h00 || bus.spi_rw !== 1'b1) begin
            failures++;
            $display("FAIL reset_spi got reg=%h data=%h rw=%b expected 00 00 1",
                     bus.spi_reg, bus.spi_data_in, bus.spi_rw);
        end
        checks++;
        if (bus.spi_send !== 1'b0 || bus.host_ack !== 1'b0 || bus.host_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_host got send=%b ack=%b rdata=%h expected 0 0 00",
                     bus.spi_send, bus.host_ack, bus.host_rdata);
        end
        checks++;
        if (init_done !== 1'b0 || init_error !== 1'b0 || err_index !== 5'd0) begin
            failures++;
            $display("FAIL reset_status got done=%b err=%b idx=%0d expected 0 0 0",
                     init_done, init_error, err_index);
        end
    endtask

    task automatic test_init_echo();
        bit hit;
        hold_reset(0);
        push_pair(0);
        push_pair(1);
        release_reset();
        wait_init(500, hit);
        checks++;
        if (!hit || init_done !== 1'b1 || init_error !== 1'b0) begin
            failures++;
            $display("FAIL init_echo got done=%b err=%b expected 1 0", init_done, init_error);
        end
        // 16 delay cycles, LOAD, then SEND registers spi_send
        checks++;
        if (first_send != SD + 2) begin
            failures++;
            $display("FAIL first_send got edge %0d expected %0d", first_send, SD + 2);
        end
        checks++;
        if (n_send != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL init_xfers got %0d left=%0d expected 4 left=0", n_send, exp_q.size());
        end
    endtask

    task automatic test_host();
        bit got;
        logic [7:0] rd;
        int w;
        push_x(1'b1, 6'h05, 8'hA7);
        host_xfer(1'b1, 6'h05, 8'hA7, got, rd, w);
        checks++;
        if (!got || w != 1) begin
            failures++;
            $display("FAIL host_write_ack got ack=%b width=%0d expected 1 1", got, w);
        end
        push_x(1'b0, 6'h05, 8'h00);
        rd_exp_q.push_back(8'hA7);
        host_xfer(1'b0, 6'h05, 8'h00, got, rd, w);
        checks++;
        if (!got || w != 1) begin
            failures++;
            $display("FAIL host_read_ack got ack=%b width=%0d expected 1 1", got, w);
        end else begin
            logic [7:0] e;
            e = rd_exp_q.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL host_rdata got %h expected %h", rd, e);
            end
        end
        checks++;
        if (n_send != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL host_xfers got %0d left=%0d expected 6 left=0", n_send, exp_q.size());
        end
    endtask

    task automatic test_read_retry();
        bit hit;
        hold_reset(1);
        push_pair(0);
        push_pair(1);
        push_pair(1);
        release_reset();
        wait_init(600, hit);
        checks++;
        if (!hit || init_done !== 1'b1 || init_error !== 1'b0) begin
            failures++;
            $display("FAIL retry_done got done=%b err=%b expected 1 0", init_done, init_error);
        end
        checks++;
        if (n_send != 6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL retry_xfers got %0d left=%0d expected 6 left=0", n_send, exp_q.size());
        end
    endtask

    task automatic test_error();
        bit hit;
        int acks;
        hold_reset(2);
        for (int i = 0; i <= MR; i++) push_pair(0);
        release_reset();
        wait_init(800, hit);
        checks++;
        if (!hit || init_error !== 1'b1 || init_done !== 1'b0 || err_index !== 5'd0) begin
            failures++;
            $display("FAIL error_status got err=%b done=%b idx=%0d expected 1 0 0",
                     init_error, init_done, err_index);
        end
        checks++;
        if (n_send != 2 * (MR + 1) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL error_xfers got %0d left=%0d expected %0d left=0",
                     n_send, exp_q.size(), 2 * (MR + 1));
        end
        acks = 0;
        bus.host_req = 1'b1;
        bus.host_rw = 1'b0;
        bus.host_reg = 6'h05;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.host_ack) acks++;
        end
        bus.host_req = 1'b0;
        checks++;
        if (acks != 0 || n_send != 2 * (MR + 1)) begin
            failures++;
            $display("FAIL error_host got acks=%0d sends=%0d expected 0 %0d",
                     acks, n_send, 2 * (MR + 1));
        end
    endtask

    task automatic test_timeout();
        bit hit;
        hold_reset(3);
        for (int i = 0; i <= MR; i++) push_x(1'b1, 6'h03, 8'h5A);
        release_reset();
        wait_init(1500, hit);
        checks++;
        if (!hit || init_error !== 1'b1 || err_index !== 5'd0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_status got err=%b idx=%0d done=%b expected 1 0 0",
                     init_error, err_index, init_done);
        end
        checks++;
        if (n_send != MR + 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_xfers got %0d left=%0d expected %0d left=0",
                     n_send, exp_q.size(), MR + 1);
        end
        // 64 waiting cycles, then CHECK, LOAD, SEND before the next request
        checks++;
        if (send_cyc.size() < 2) begin
            failures++;
            $display("FAIL timeout_gap got %0d sends expected >=2", send_cyc.size());
        end else if (send_cyc[1] - send_cyc[0] != TO + 3) begin
            failures++;
            $display("FAIL timeout_gap got %0d expected %0d",
                     send_cyc[1] - send_cyc[0], TO + 3);
        end
    endtask

    task automatic test_reset_midway();
        bit hit;
        int lim;
        hold_reset(0);
        push_pair(0);
        push_x(1'b1, 6'h05, 8'h3C);
        release_reset();
        lim = 0;
        while (n_send < 3 && lim < 500) begin
            @(negedge clk);
            lim++;
        end
        checks++;
        if (n_send < 3) begin
            failures++;
            $display("FAIL midway_reach got sends=%0d expected 3", n_send);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.spi_reg !== 6'h00 || bus.spi_data_in !== 8'h00 || bus.spi_rw !== 1'b1 ||
            bus.spi_send !== 1'b0 || init_done !== 1'b0 || bus.host_ack !== 1'b0) begin
            failures++;
            $display("FAIL midway_async got reg=%h data=%h rw=%b send=%b done=%b expected 00 00 1 0 0",
                     bus.spi_reg, bus.spi_data_in, bus.spi_rw, bus.spi_send, init_done);
        end
        hold_reset(0);
        push_pair(0);
        push_pair(1);
        release_reset();
        wait_init(500, hit);
        checks++;
        if (!hit || init_done !== 1'b1 || n_send != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midway_restart got done=%b sends=%0d left=%0d expected 1 4 0",
                     init_done, n_send, exp_q.size());
        end
    endtask

    initial begin
        bus.host_req   = 1'b0;
        bus.host_rw    = 1'b0;
        bus.host_reg   = 6'h00;
        bus.host_wdata = 8'h00;
        test_reset();
        test_init_echo();
        test_host();
        test_read_retry();
        test_error();
        test_timeout();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
